demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the receive-side counterpart of the 2:1 data mux.
- Steers each incoming WIDTH-bit word to destination A (sel=0) or destination B (sel=1).
- Each destination has a one-entry output buffer and a wrap-around delivered-word counter.
- Sits between a single producer and two independent consumers, which may stall separately.

Parameters:
- WIDTH, 3: data word width in bits.
- CNT_W, 8: width of each delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  data word from the producer.
- sel  input  1  destination select: 0 = A, 1 = B.
- in_valid  input  1  producer has a word on in/sel.
- in_ready  output  1  the selected destination can accept the word this cycle.
- out_a  output  WIDTH  destination A data.
- a_valid  output  1  out_a holds an undelivered word.
- a_ready  input  1  consumer A accepts out_a this cycle.
- out_b  output  WIDTH  destination B data.
- b_valid  output  1  out_b holds an undelivered word.
- b_ready  input  1  consumer B accepts out_b this cycle.
- cnt_a  output  CNT_W  number of words delivered on A, modulo 2^CNT_W.
- cnt_b  output  CNT_W  number of words delivered on B, modulo 2^CNT_W.

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: out_a=0, out_b=0, a_valid=0, b_valid=0, cnt_a=0, cnt_b=0.
  - Reset asserted mid-operation discards any buffered or pending words immediately.
  - First possible accept is on the first rising edge with rst=0.
- in_ready is combinational:
  - sel=0: in_ready = !a_valid | a_ready.
  - sel=1: in_ready = !b_valid | b_ready.
  - in_ready is independent of in_valid.
- Accept occurs on a rising edge where in_valid & in_ready.
  - The word loads into the selected buffer and its valid bit is 1 from the next cycle. Input-to-output latency is 1 cycle.
  - The non-selected buffer is untouched: its data, valid bit and counter are unaffected.
- Per-buffer update each edge, in priority order:
  - Accept targets this buffer: load data, valid<=1. This covers simultaneous drain and refill, giving back-to-back throughput of 1 word/cycle per destination.
  - Otherwise, if valid & ready: valid<=0 and the data register holds its last value.
  - Otherwise: hold.
- Delivery occurs on an edge where x_valid & x_ready.
  - The matching counter increments by 1 and wraps from 2^CNT_W-1 to 0.
  - Counters never change on accept, only on delivery.
- While x_valid=1 & x_ready=0, out_x is stable, with no overwrite possible (in_ready=0 for that destination).
- Stall isolation: a stalled A does not block traffic to B. Words with sel=1 continue at full rate while A is full.
- Producer rule: while in_valid=1 & in_ready=0, the producer holds in and sel stable. The block has no internal arbitration or reordering.
- x_ready asserted while x_valid=0 has no effect.
- Simultaneous events:
  - A delivery on A and an accept into B in the same cycle are fully independent.
  - Delivery and counter increment on both outputs in the same cycle are allowed.

Test Plan:
- Reset check: assert rst mid-cycle with a_valid=1 and cnt_a=5 -> outputs and counters are 0 immediately, without waiting for clk; after release, the first word in=3'b101, sel=0, a_ready=1 appears on out_a with a_valid=1 one cycle later.
- Steering: send 3'b011 with sel=0, then 3'b110 with sel=1, both consumers ready -> out_a=011 then out_b=110, each valid for exactly 1 cycle; cnt_a=1, cnt_b=1; out_a holds 011 after a_valid drops.
- Back-pressure: a_ready=0, send 3'b001 with sel=0 -> a_valid=1; in_ready=0 while sel=0 with in=3'b111 held; out_a stays 001 for 4 cycles. Raise a_ready -> 001 is delivered and 111 is loaded on the same edge; cnt_a=1, then 2.
- Isolation: A stalled and full; stream 3'b010, 3'b100, 3'b111 with sel=1 and b_ready=1 -> in_ready=1 each cycle, B delivers all three on consecutive cycles, cnt_b=3, A unchanged.
- Throughput: both ready, in_valid=1 continuously, sel toggling every cycle for 10 words -> 5 deliveries on each output, no lost words, data order preserved per destination.
- Counter wrap: deliver 257 words to B with CNT_W=8 -> cnt_b passes 255 then reads 0 and then 1; cnt_a remains 0.

Source files
------------

// File: rtl/demux_router.sv
// Registered 1:2 demux: word goes to A (sel=0) or B (sel=1) one-entry buffer, 1-cycle latency.
// in_ready follows the selected buffer only, so a stalled destination never blocks the other.
module demux_router #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [WIDTH-1:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;
  logic             a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             acc_a, acc_b, dlv_a, dlv_b;

  assign in_ready = sel ? (!b_vld_q | b_ready) : (!a_vld_q | a_ready);
  assign acc_a    = in_valid & in_ready & ~sel;
  assign acc_b    = in_valid & in_ready & sel;
  assign dlv_a    = a_vld_q & a_ready;
  assign dlv_b    = b_vld_q & b_ready;

  // Accept wins over drain so a buffer can empty and refill on the same edge.
  always_comb begin
    a_dat_d = a_dat_q;
    a_vld_d = a_vld_q;
    b_dat_d = b_dat_q;
    b_vld_d = b_vld_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (acc_a) begin
      a_dat_d = in;
      a_vld_d = 1'b1;
    end else if (dlv_a) begin
      a_vld_d = 1'b0;
    end
    if (acc_b) begin
      b_dat_d = in;
      b_vld_d = 1'b1;
    end else if (dlv_b) begin
      b_vld_d = 1'b0;
    end
    if (dlv_a) cnt_a_d = cnt_a_q + 1'b1;
    if (dlv_b) cnt_b_d = cnt_b_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dat_q <= '0;
      a_vld_q <= 1'b0;
      b_dat_q <= '0;
      b_vld_q <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      a_dat_q <= a_dat_d;
      a_vld_q <= a_vld_d;
      b_dat_q <= b_dat_d;
      b_vld_q <= b_vld_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign out_a   = a_dat_q;
  assign a_valid = a_vld_q;
  assign out_b   = b_dat_q;
  assign b_valid = b_vld_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: vector table for steering/back-pressure/isolation,
// hand sequences for async reset, alternating throughput and counter wrap.
module tb_demux_router;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] din;
  logic       sel, in_valid, a_ready, b_ready;
  logic       in_ready, a_valid, b_valid;
  logic [2:0] out_a, out_b;
  logic [7:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_router #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(din), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_a(out_a), .a_valid(a_valid), .a_ready(a_ready),
    .out_b(out_b), .b_valid(b_valid), .b_ready(b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  // Observation word: {in_ready, out_a, a_valid, out_b, b_valid, cnt_a, cnt_b}
  typedef struct packed {
    logic [2:0]  din;
    logic        sel;
    logic        iv;
    logic        ar;
    logic        br;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic [2:0] d, input logic s, input logic iv,
                              input logic ar, input logic br, input logic ir,
                              input logic [2:0] oa, input logic av, input logic [2:0] ob,
                              input logic bv, input logic [7:0] ca, input logic [7:0] cb);
    vec_t v;
    v.din = d;
    v.sel = s;
    v.iv  = iv;
    v.ar  = ar;
    v.br  = br;
    v.exp = {ir, oa, av, ob, bv, ca, cb};
    return v;
  endfunction

  function automatic logic [24:0] obs();
    return {in_ready, out_a, a_valid, out_b, b_valid, cnt_a, cnt_b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [2:0] d, input logic s, input logic iv,
                       input logic ar, input logic br);
    @(negedge clk);
    din      = d;
    sel      = s;
    in_valid = iv;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask

  initial begin
    logic [2:0] w;
    logic [7:0] mca, mcb;
    int         p;

    // Each row: inputs for the cycle, expected outputs seen before that cycle's edge.
    //            din    s  iv ar br  ir  oa   av  ob   bv  ca  cb
    tbl[0]  = mk(3'd3, 0, 1, 1, 1,  1, 3'd0, 0, 3'd0, 0, 0, 0);
    tbl[1]  = mk(3'd6, 1, 1, 1, 1,  1, 3'd3, 1, 3'd0, 0, 0, 0);
    tbl[2]  = mk(3'd0, 0, 0, 1, 1,  1, 3'd3, 0, 3'd6, 1, 1, 0);
    tbl[3]  = mk(3'd0, 0, 0, 1, 1,  1, 3'd3, 0, 3'd6, 0, 1, 1);
    tbl[4]  = mk(3'd1, 0, 1, 0, 1,  1, 3'd3, 0, 3'd6, 0, 1, 1);
    tbl[5]  = mk(3'd7, 0, 1, 0, 1,  0, 3'd1, 1, 3'd6, 0, 1, 1);
    tbl[6]  = mk(3'd7, 0, 1, 0, 1,  0, 3'd1, 1, 3'd6, 0, 1, 1);
    tbl[7]  = mk(3'd7, 0, 1, 0, 1,  0, 3'd1, 1, 3'd6, 0, 1, 1);
    tbl[8]  = mk(3'd7, 0, 1, 0, 1,  0, 3'd1, 1, 3'd6, 0, 1, 1);
    tbl[9]  = mk(3'd7, 0, 1, 1, 1,  1, 3'd1, 1, 3'd6, 0, 1, 1);
    tbl[10] = mk(3'd0, 0, 0, 1, 1,  1, 3'd7, 1, 3'd6, 0, 2, 1);
    tbl[11] = mk(3'd0, 0, 0, 1, 1,  1, 3'd7, 0, 3'd6, 0, 3, 1);
    tbl[12] = mk(3'd5, 0, 1, 0, 1,  1, 3'd7, 0, 3'd6, 0, 3, 1);
    tbl[13] = mk(3'd2, 1, 1, 0, 1,  1, 3'd5, 1, 3'd6, 0, 3, 1);
    tbl[14] = mk(3'd4, 1, 1, 0, 1,  1, 3'd5, 1, 3'd2, 1, 3, 1);
    tbl[15] = mk(3'd7, 1, 1, 0, 1,  1, 3'd5, 1, 3'd4, 1, 3, 2);
    tbl[16] = mk(3'd0, 1, 0, 0, 1,  1, 3'd5, 1, 3'd7, 1, 3, 3);
    tbl[17] = mk(3'd0, 0, 0, 0, 1,  0, 3'd5, 1, 3'd7, 0, 3, 4);
    tbl[18] = mk(3'd0, 0, 0, 1, 0,  1, 3'd5, 1, 3'd7, 0, 3, 4);
    tbl[19] = mk(3'd0, 1, 0, 1, 1,  1, 3'd5, 0, 3'd7, 0, 4, 4);
    tbl[20] = mk(3'd0, 1, 0, 1, 1,  1, 3'd5, 0, 3'd7, 0, 4, 4);
    tbl[21] = mk(3'd3, 0, 1, 0, 0,  1, 3'd5, 0, 3'd7, 0, 4, 4);
    tbl[22] = mk(3'd6, 1, 1, 0, 0,  1, 3'd3, 1, 3'd7, 0, 4, 4);
    tbl[23] = mk(3'd0, 0, 0, 1, 1,  1, 3'd3, 1, 3'd6, 1, 4, 4);
    tbl[24] = mk(3'd0, 0, 0, 0, 0,  1, 3'd3, 0, 3'd6, 0, 5, 5);

    rst = 1'b1; din = '0; sel = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    #1;
    chk("reset_state", {out_a, a_valid, out_b, b_valid, cnt_a, cnt_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].din, tbl[i].sel, tbl[i].iv, tbl[i].ar, tbl[i].br);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Park a word in A with cnt_a=5, then assert reset between clock edges.
    drive(3'd7, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_a", {a_valid, out_a, cnt_a}, {1'b1, 3'd7, 8'd5});
    rst = 1'b1;
    #1;
    chk("async_rst", {out_a, a_valid, out_b, b_valid, cnt_a, cnt_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    din = 3'd5; sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    chk("post_rst", obs(), {1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0});
    drive(3'd0, 0, 0, 1, 1);
    chk("first_word", {a_valid, out_a, cnt_a}, {1'b1, 3'd5, 8'd0});
    drive(3'd0, 0, 0, 0, 0);
    chk("first_deliv", {a_valid, out_a, cnt_a}, {1'b0, 3'd5, 8'd1});

    // Alternating destinations at full rate, both consumers ready.
    mca = 8'd1;
    mcb = 8'd0;
    for (int i = 0; i <= 10; i++) begin
      w = 3'(i + 3);
      drive(w, i[0], (i < 10), 1, 1);
      if (i < 10) chk($sformatf("thr_rdy%0d", i), in_ready, 1'b1);
      chk($sformatf("thr_cnt%0d", i), {cnt_a, cnt_b}, {mca, mcb});
      if (i >= 1) begin
        p = (i - 1) % 2;
        w = 3'(i + 2);
        if (p == 0) begin
          chk($sformatf("thr_a%0d", i), {a_valid, out_a, b_valid}, {1'b1, w, 1'b0});
          mca = mca + 8'd1;
        end else begin
          chk($sformatf("thr_b%0d", i), {b_valid, out_b, a_valid}, {1'b1, w, 1'b0});
          mcb = mcb + 8'd1;
        end
      end
    end
    drive(3'd0, 0, 0, 0, 0);
    chk("thr_total", {a_valid, b_valid, cnt_a, cnt_b}, {1'b0, 1'b0, 8'd6, 8'd5});

    // Counter wrap: 257 back-to-back words into B from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mcb = 8'd0;
    for (int k = 0; k <= 258; k++) begin
      drive(3'(k), 1, (k < 257), 0, 1);
      if (k < 257) chk($sformatf("wrap_rdy%0d", k), in_ready, 1'b1);
      chk($sformatf("wrap_cnt%0d", k), {cnt_a, cnt_b}, {8'd0, mcb});
      if (k >= 1 && k <= 257) begin
        w = 3'(k - 1);
        chk($sformatf("wrap_b%0d", k), {b_valid, out_b}, {1'b1, w});
        mcb = mcb + 8'd1;
      end else begin
        chk($sformatf("wrap_bv%0d", k), b_valid, 1'b0);
      end
      if (k == 256) chk("wrap_255", cnt_b, 8'd255);
      if (k == 257) chk("wrap_0", cnt_b, 8'd0);
      if (k == 258) chk("wrap_1", {cnt_a, cnt_b}, {8'd0, 8'd1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
